// File: rtl/gray_pos_ctrl.sv
// Gray-code position controller: takes a target over valid/ready, walks the
// 8-position ring in the shorter direction, one step per STEP_DIV clocks.
module gray_pos_ctrl #(
    parameter int STEP_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_target_i,
    input  logic       abort_i,
    output logic [2:0] gray_o,
    output logic [2:0] pos_o,
    output logic       dir_o,
    output logic       step_pulse_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(STEP_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic [2:0]    gray_q, gray_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic          done_q, done_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    rem_q, rem_d;

    logic [2:0]    diff;
    logic [2:0]    pos_nx;

    assign diff   = cmd_target_i - pos_q;
    assign pos_nx = dir_q ? (pos_q + 3'd1) : (pos_q - 3'd1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        gray_d  = gray_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        timer_d = timer_q;
        rem_d   = rem_q;
        if (state_q == IDLE) begin
            if (cmd_valid_i) begin
                if (diff == 3'd0) begin
                    done_d = 1'b1;
                end else begin
                    // A half-ring tie (diff == 4) resolves upward.
                    dir_d   = (diff <= 3'd4);
                    rem_d   = (diff <= 3'd4) ? diff : (3'd0 - diff);
                    timer_d = TLOAD;
                    state_d = RUN;
                end
            end
        end else begin
            if (abort_i) begin
                state_d = IDLE;
            end else if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
            end else begin
                pos_d   = pos_nx;
                gray_d  = pos_nx ^ (pos_nx >> 1);
                step_d  = 1'b1;
                rem_d   = rem_q - 3'd1;
                timer_d = TLOAD;
                if (rem_q == 3'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pos_q   <= 3'd0;
            gray_q  <= 3'd0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            timer_q <= '0;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            gray_q  <= gray_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            done_q  <= done_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == RUN);
    assign gray_o       = gray_q;
    assign pos_o        = pos_q;
    assign dir_o        = dir_q;
    assign step_pulse_o = step_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_gray_pos_ctrl.sv
// Bench for gray_pos_ctrl: two instances (STEP_DIV 4 and 1) checked every
// cycle against a move-level model driven by elapsed cycles since handshake.
module tb_gray_pos_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cv   [2];
    logic       abt  [2];
    logic [2:0] tgt  [2];
    logic       rdy  [2];
    logic [2:0] g    [2];
    logic [2:0] p    [2];
    logic       dr   [2];
    logic       sp   [2];
    logic       bz   [2];
    logic       dn   [2];

    int vecs = 0;
    int errs = 0;

    // move-level reference model
    int         D     [2];
    int         n_m   [2];
    int         p0_m  [2];
    int         rem_m [2];
    bit         act_m [2];
    bit         up_m  [2];
    bit         pul_m [2];
    bit         dn_m  [2];
    logic [2:0] pos_m [2];

    always #5 clk = ~clk;

    gray_pos_ctrl #(.STEP_DIV(4)) u_d4 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cv[0]), .cmd_ready_o(rdy[0]),
        .cmd_target_i(tgt[0]), .abort_i(abt[0]), .gray_o(g[0]), .pos_o(p[0]),
        .dir_o(dr[0]), .step_pulse_o(sp[0]), .busy_o(bz[0]), .done_o(dn[0])
    );

    gray_pos_ctrl #(.STEP_DIV(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cv[1]), .cmd_ready_o(rdy[1]),
        .cmd_target_i(tgt[1]), .abort_i(abt[1]), .gray_o(g[1]), .pos_o(p[1]),
        .dir_o(dr[1]), .step_pulse_o(sp[1]), .busy_o(bz[1]), .done_o(dn[1])
    );

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n_m[i] = 0; p0_m[i] = 0; rem_m[i] = 0;
            act_m[i] = 0; up_m[i] = 0; pul_m[i] = 0; dn_m[i] = 0;
            pos_m[i] = 3'd0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pos%0d", i),   p[i], pos_m[i]);
            chk($sformatf("gray%0d", i),  g[i], pos_m[i] ^ (pos_m[i] >> 1));
            chk($sformatf("dir%0d", i),   {2'b0, dr[i]},  {2'b0, up_m[i]});
            chk($sformatf("step%0d", i),  {2'b0, sp[i]},  {2'b0, pul_m[i]});
            chk($sformatf("busy%0d", i),  {2'b0, bz[i]},  {2'b0, act_m[i]});
            chk($sformatf("ready%0d", i), {2'b0, rdy[i]}, {2'b0, !act_m[i]});
            chk($sformatf("done%0d", i),  {2'b0, dn[i]},  {2'b0, dn_m[i]});
        end
    endtask

    // One clock: sample inputs before the edge, advance the model, check after.
    task automatic cycle();
        bit r;
        bit hs [2];
        bit ab [2];
        int steps;
        int d;
        r = rst;
        for (int i = 0; i < 2; i++) begin
            hs[i] = cv[i] && !act_m[i];
            ab[i] = abt[i] && act_m[i];
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                pul_m[i] = 0;
                dn_m[i]  = 0;
                if (ab[i]) begin
                    act_m[i] = 0;
                end else if (act_m[i]) begin
                    n_m[i]++;
                    steps = (n_m[i] / D[i] < rem_m[i]) ? n_m[i] / D[i] : rem_m[i];
                    pos_m[i] = 3'(up_m[i] ? p0_m[i] + steps : p0_m[i] - steps);
                    pul_m[i] = (n_m[i] % D[i] == 0);
                    if (n_m[i] == rem_m[i] * D[i]) begin
                        dn_m[i]  = 1;
                        act_m[i] = 0;
                    end
                end else if (hs[i]) begin
                    d = (int'(tgt[i]) - int'(pos_m[i]) + 8) % 8;
                    if (d == 0) begin
                        dn_m[i] = 1;
                    end else begin
                        up_m[i]  = (d <= 4);
                        rem_m[i] = (d <= 4) ? d : 8 - d;
                        p0_m[i]  = int'(pos_m[i]);
                        n_m[i]   = 0;
                        act_m[i] = 1;
                    end
                end
            end
        end
        check_all();
    endtask

    task automatic go(input int i, input int t, input int ncyc);
        cv[i]  = 1'b1;
        tgt[i] = 3'(t);
        cycle();
        cv[i]  = 1'b0;
        repeat (ncyc) cycle();
    endtask

    initial begin
        D[0] = 4;
        D[1] = 1;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0; abt[i] = 1'b0; tgt[i] = 3'd0;
        end
        #1;
        model_reset();
        check_all();
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // down move 0 -> 5: 3 steps, gray 100,101,111
        go(0, 5, 14);
        chk("dn_gray", g[0], 3'b111);
        chk("dn_dir", {2'b0, dr[0]}, 3'd0);

        // back to 0, then the tie case 0 -> 4 goes up 4 steps
        go(0, 0, 14);
        go(0, 4, 18);
        chk("tie_pos", p[0], 3'd4);
        chk("tie_gray", g[0], 3'b110);

        // STEP_DIV=1 wraparound 6 -> 1, then a zero-length command in the done cycle
        go(1, 6, 4);
        go(1, 1, 3);
        chk("wrap_gray", g[1], 3'b001);
        chk("wrap_done", {2'b0, dn[1]}, 3'd1);
        cv[1] = 1'b1;
        tgt[1] = 3'd1;
        cycle();
        cv[1] = 1'b0;
        chk("b2b_done", {2'b0, dn[1]}, 3'd1);
        chk("b2b_step", {2'b0, sp[1]}, 3'd0);
        cycle();

        // abort the cycle after the first step_pulse of 0 -> 3
        go(0, 0, 18);
        cv[0] = 1'b1;
        tgt[0] = 3'd3;
        cycle();
        cv[0] = 1'b0;
        repeat (5) cycle();
        abt[0] = 1'b1;
        cycle();
        abt[0] = 1'b0;
        repeat (4) cycle();
        chk("abt_pos", p[0], 3'd1);
        chk("abt_gray", g[0], 3'b001);
        chk("abt_rdy", {2'b0, rdy[0]}, 3'd1);

        // abort coincident with timer expiry: no step
        cv[0] = 1'b1;
        tgt[0] = 3'd3;
        cycle();
        cv[0] = 1'b0;
        repeat (3) cycle();
        abt[0] = 1'b1;
        cycle();
        abt[0] = 1'b0;
        repeat (2) cycle();
        chk("abt0_pos", p[0], 3'd1);

        // asynchronous reset between steps of 1 -> 6
        cv[0] = 1'b1;
        tgt[0] = 3'd6;
        cycle();
        cv[0] = 1'b0;
        repeat (6) cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        rst = 1'b0;
        cycle();
        go(0, 2, 10);
        chk("rst_gray", g[0], 3'b011);

        // random commands and aborts on both instances
        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                cv[i]  = ($urandom_range(0, 3) == 0);
                tgt[i] = 3'($urandom_range(0, 7));
                abt[i] = ($urandom_range(0, 15) == 0);
            end
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0;
            abt[i] = 1'b0;
        end
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
